// File: rtl/display_scan_if.sv
// Bundle between the display scan controller and its surroundings: time base,
// mode requester and the 7-segment digit decoder / anode drivers.
interface display_scan_if;
  logic [15:0] time_digits_i;
  logic [63:0] scroll_data_i;
  logic        sec_pulse_i;
  logic        mode_req_i;
  logic [1:0]  mode_sel_i;
  logic        mode_ack_o;
  logic [1:0]  type_o;
  logic [1:0]  address_o;
  logic [3:0]  digit_o;
  logic [5:0]  loopindex_o;
  logic        flag_sec_o;
  logic [3:0]  an_n_o;

  modport slave (
    input  time_digits_i, scroll_data_i, sec_pulse_i, mode_req_i, mode_sel_i,
    output mode_ack_o, type_o, address_o, digit_o, loopindex_o, flag_sec_o, an_n_o
  );

  modport master (
    output time_digits_i, scroll_data_i, sec_pulse_i, mode_req_i, mode_sel_i,
    input  mode_ack_o, type_o, address_o, digit_o, loopindex_o, flag_sec_o, an_n_o
  );
endinterface

// File: rtl/display_scan_controller.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display: digit scanning,
// seconds-dot blink, message scrolling and frame-aligned mode switching.
module display_scan_controller #(
  parameter int SCAN_DIV      = 16,
  parameter int SCROLL_FRAMES = 64,
  parameter int SCROLL_LEN    = 16,
  parameter int BLINK_CYC     = 16384
) (
  input  logic          clk_in,
  input  logic          reset,
  display_scan_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV) + 1;
  localparam int FW = $clog2(SCROLL_FRAMES) + 1;
  localparam int BW = $clog2(BLINK_CYC) + 1;

  typedef enum logic [1:0] {
    M_OFF    = 2'b00,
    M_CLOCK  = 2'b01,
    M_SCROLL = 2'b10
  } mode_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    addr_q, addr_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [5:0]    loop_q, loop_d;
  logic [BW-1:0] blink_q, blink_d;
  mode_e         mode_q, mode_d;
  mode_e         latch_q, latch_d;
  logic          pend_q, pend_d;
  logic          ack_q, ack_d;
  logic [3:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;
  logic          scan_tick, frame_tick;
  logic [6:0]    idx;

  always_comb begin
    scan_tick  = (presc_q == PW'(SCAN_DIV - 1));
    frame_tick = scan_tick && (addr_q == 2'd3);
    presc_d    = scan_tick ? '0 : presc_q + 1'b1;
    addr_d     = scan_tick ? addr_q + 2'd1 : addr_q;

    mode_d  = mode_q;
    latch_d = latch_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    frame_d = frame_q;
    loop_d  = loop_q;

    if (mode_q == M_SCROLL && frame_tick) begin
      if (frame_q == FW'(SCROLL_FRAMES - 1)) begin
        frame_d = '0;
        loop_d  = (loop_q == 6'(SCROLL_LEN - 1)) ? 6'd0 : loop_q + 6'd1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // A request latched on a frame-tick edge waits for the following frame.
    if (frame_tick && pend_q) begin
      mode_d  = latch_q;
      loop_d  = '0;
      frame_d = '0;
      pend_d  = 1'b0;
      ack_d   = 1'b1;
    end else if (bus.mode_req_i && !pend_q && !ack_q) begin
      latch_d = (bus.mode_sel_i == 2'b11) ? M_OFF : mode_e'(bus.mode_sel_i);
      pend_d  = 1'b1;
    end

    if (bus.sec_pulse_i)  blink_d = BW'(BLINK_CYC);
    else if (blink_q != 0) blink_d = blink_q - 1'b1;
    else                  blink_d = blink_q;

    // Slot a shows message nibble loopindex+3-a, so the left digit leads.
    idx = {1'b0, loop_d} + 7'd3 - {5'd0, addr_d};
    case (mode_d)
      M_CLOCK:  digit_d = bus.time_digits_i[{addr_d, 2'b00} +: 4];
      M_SCROLL: digit_d = (idx < 7'(SCROLL_LEN)) ? bus.scroll_data_i[{idx[3:0], 2'b00} +: 4]
                                                  : 4'd10;
      default:  digit_d = 4'd0;
    endcase

    // Decoder registers segments, so anodes trail the scan by one cycle.
    an_d = (mode_q == M_OFF) ? 4'hF : ~(4'b0001 << addr_q);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      addr_q  <= '0;
      frame_q <= '0;
      loop_q  <= '0;
      blink_q <= '0;
      mode_q  <= M_OFF;
      latch_q <= M_OFF;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      digit_q <= '0;
      an_q    <= 4'hF;
    end else begin
      presc_q <= presc_d;
      addr_q  <= addr_d;
      frame_q <= frame_d;
      loop_q  <= loop_d;
      blink_q <= blink_d;
      mode_q  <= mode_d;
      latch_q <= latch_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      digit_q <= digit_d;
      an_q    <= an_d;
    end
  end

  assign bus.mode_ack_o  = ack_q;
  assign bus.type_o      = mode_q;
  assign bus.address_o   = addr_q;
  assign bus.digit_o     = digit_q;
  assign bus.loopindex_o = loop_q;
  assign bus.flag_sec_o  = (blink_q != '0);
  assign bus.an_n_o      = an_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with a small parameter set: scan, clock
// digits, blink, scrolling, mode switching and reset abandonment.
module tb_display_scan_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_scan_if ifc ();

  display_scan_controller #(
    .SCAN_DIV(4), .SCROLL_FRAMES(2), .SCROLL_LEN(5), .BLINK_CYC(10)
  ) dut (
    .clk_in(clk),
    .reset (rst),
    .bus   (ifc)
  );

  int cyc;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    int         cyc;
    logic [1:0] addr;
    logic [3:0] dig;
    logic [3:0] an;
    logic [5:0] loop;
    logic       ack;
    int         act;
    logic [1:0] sel;
  } vec_t;
  vec_t vq[$];

  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic expect_v(input string nm, input logic [31:0] e);
    sb_t s;
    s.nm  = nm;
    s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic observe(input logic [31:0] act);
    sb_t s;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0h with no expected value", act);
    end else begin
      s = sbq.pop_front();
      if (act !== s.exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h", s.nm, act, s.exp);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
    expect_v(nm, e);
    observe(act);
  endtask

  function automatic vec_t mk(input int c, input int a, input int d, input int an,
                              input int l, input int ack, input int act = 0,
                              input int sel = 0);
    vec_t v;
    v.cyc  = c;
    v.addr = a[1:0];
    v.dig  = d[3:0];
    v.an   = an[3:0];
    v.loop = l[5:0];
    v.ack  = ack[0];
    v.act  = act;
    v.sel  = sel[1:0];
    return v;
  endfunction

  task automatic run_vecs(input int base, input string tag);
    foreach (vq[i]) begin
      int c;
      c = base + vq[i].cyc;
      expect_v($sformatf("%s_addr@%0d", tag, c), 32'(vq[i].addr));
      expect_v($sformatf("%s_digit@%0d", tag, c), 32'(vq[i].dig));
      expect_v($sformatf("%s_an_n@%0d", tag, c), 32'(vq[i].an));
      expect_v($sformatf("%s_loop@%0d", tag, c), 32'(vq[i].loop));
      expect_v($sformatf("%s_ack@%0d", tag, c), 32'(vq[i].ack));
      run_to(c);
      observe(32'(ifc.address_o));
      observe(32'(ifc.digit_o));
      observe(32'(ifc.an_n_o));
      observe(32'(ifc.loopindex_o));
      observe(32'(ifc.mode_ack_o));
      if (vq[i].act == 1) begin
        ifc.mode_req_i = 1'b1;
        ifc.mode_sel_i = vq[i].sel;
      end else if (vq[i].act == 2) begin
        ifc.mode_req_i = 1'b0;
      end
    end
    vq.delete();
  endtask

  task automatic wait_ack(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (ifc.mode_ack_o) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, rises, at, acks;
    logic prev;
    ifc.time_digits_i = 16'h1234;
    ifc.scroll_data_i = 64'hFFFF_FFFF_FFF5_4321;
    ifc.sec_pulse_i   = 1'b0;
    ifc.mode_req_i    = 1'b0;
    ifc.mode_sel_i    = 2'b00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state, scan timing, then a clock-mode request at cycle 3.
    chk("rst_type", 32'(ifc.type_o), 32'd0);
    chk("rst_flag", 32'(ifc.flag_sec_o), 32'd0);
    vq.push_back(mk(0,  0, 0, 'hF, 0, 0));
    vq.push_back(mk(2,  0, 0, 'hF, 0, 0, 1, 1));
    vq.push_back(mk(3,  0, 0, 'hF, 0, 0));
    vq.push_back(mk(4,  1, 0, 'hF, 0, 0));
    vq.push_back(mk(8,  2, 0, 'hF, 0, 0));
    vq.push_back(mk(12, 3, 0, 'hF, 0, 0));
    vq.push_back(mk(15, 3, 0, 'hF, 0, 0));
    vq.push_back(mk(16, 0, 4, 'hF, 0, 1, 2));
    vq.push_back(mk(17, 0, 4, 'hE, 0, 0));
    vq.push_back(mk(20, 1, 3, 'hE, 0, 0));
    vq.push_back(mk(21, 1, 3, 'hD, 0, 0));
    vq.push_back(mk(24, 2, 2, 'hD, 0, 0));
    vq.push_back(mk(25, 2, 2, 'hB, 0, 0));
    vq.push_back(mk(28, 3, 1, 'hB, 0, 0));
    vq.push_back(mk(29, 3, 1, 'h7, 0, 0));
    vq.push_back(mk(32, 0, 4, 'h7, 0, 0));
    vq.push_back(mk(33, 0, 4, 'hE, 0, 0));
    run_vecs(0, "clk");
    chk("clk_type", 32'(ifc.type_o), 32'd1);

    // Single seconds pulse.
    run_to(40);
    chk("blink_pre", 32'(ifc.flag_sec_o), 32'd0);
    ifc.sec_pulse_i = 1'b1;
    tick();
    ifc.sec_pulse_i = 1'b0;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (ifc.flag_sec_o) hi++;
      tick();
    end
    chk("blink_single_len", 32'(hi), 32'd10);

    // Retrigger six cycles into the count.
    run_to(80);
    ifc.sec_pulse_i = 1'b1;
    tick();
    ifc.sec_pulse_i = 1'b0;
    hi = 0;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.flag_sec_o) hi++;
      if (ifc.flag_sec_o && !prev) rises++;
      prev = ifc.flag_sec_o;
      ifc.sec_pulse_i = (cyc == 86);
      tick();
    end
    ifc.sec_pulse_i = 1'b0;
    chk("blink_retrig_len", 32'(hi), 32'd16);
    chk("blink_retrig_rises", 32'(rises), 32'd1);

    // Scroll mode, applied at frame tick 144.
    run_to(130);
    ifc.mode_req_i = 1'b1;
    ifc.mode_sel_i = 2'b10;
    vq.push_back(mk(0,   0, 4,   'h7, 0, 1, 2));
    vq.push_back(mk(4,   1, 3,   'hE, 0, 0));
    vq.push_back(mk(8,   2, 2,   'hD, 0, 0));
    vq.push_back(mk(12,  3, 1,   'hB, 0, 0));
    vq.push_back(mk(31,  3, 1,   'h7, 0, 0));
    vq.push_back(mk(32,  0, 5,   'h7, 1, 0));
    vq.push_back(mk(64,  0, 'hA, 'h7, 2, 0));
    vq.push_back(mk(68,  1, 5,   'hE, 2, 0));
    vq.push_back(mk(72,  2, 4,   'hD, 2, 0));
    vq.push_back(mk(76,  3, 3,   'hB, 2, 0));
    vq.push_back(mk(128, 0, 'hA, 'h7, 4, 0));
    vq.push_back(mk(140, 3, 5,   'hB, 4, 0));
    vq.push_back(mk(160, 0, 4,   'h7, 0, 0));
    run_vecs(144, "scr");
    chk("scr_type", 32'(ifc.type_o), 32'd2);

    // Select 11 maps to off; request held past the ack becomes a new request.
    run_to(310);
    ifc.mode_req_i = 1'b1;
    ifc.mode_sel_i = 2'b11;
    wait_ack(40, at);
    chk("off_ack_cycle", 32'(at), 32'd320);
    chk("off_type", 32'(ifc.type_o), 32'd0);
    chk("off_loop", 32'(ifc.loopindex_o), 32'd0);
    chk("off_an_lag", 32'(ifc.an_n_o), 32'h7);
    ifc.mode_sel_i = 2'b01;
    tick();
    chk("off_ack_pulse_end", 32'(ifc.mode_ack_o), 32'd0);
    chk("off_an_blank", 32'(ifc.an_n_o), 32'hF);
    wait_ack(30, at);
    chk("held_req_ack_cycle", 32'(at), 32'd336);
    chk("held_req_type", 32'(ifc.type_o), 32'd1);
    ifc.mode_req_i = 1'b0;

    // Reset while a request is pending abandons it.
    run_to(340);
    ifc.mode_req_i = 1'b1;
    ifc.mode_sel_i = 2'b10;
    tick();
    tick();
    ifc.mode_req_i = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("async_rst_type", 32'(ifc.type_o), 32'd0);
    chk("async_rst_addr", 32'(ifc.address_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_an", 32'(ifc.an_n_o), 32'hF);
    chk("rst2_digit", 32'(ifc.digit_o), 32'd0);
    chk("rst2_loop", 32'(ifc.loopindex_o), 32'd0);
    chk("rst2_ack", 32'(ifc.mode_ack_o), 32'd0);
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ifc.mode_ack_o) acks++;
    end
    chk("rst2_no_ack", 32'(acks), 32'd0);
    chk("rst2_type", 32'(ifc.type_o), 32'd0);
    chk("rst2_an_off", 32'(ifc.an_n_o), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
